aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_round_ctrl_if.sv | 46 ++++
 rtl/aes_rcon_gen.sv | 39 +++
 rtl/aes_round_ctrl.sv | 113 +++++++++++
 tb/tb_aes_round_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types, constants and helpers for the AES round controller.
package aes_pkg;

    // Controller states; the encoding is shared by every block that decodes the state.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StRound = 3'd2,
        StFinal = 3'd3,
        StDone  = 3'd4
    } aes_state_e;

    localparam int unsigned NUM_ROUNDS = 10;
    localparam logic [7:0]  RCON_INIT  = 8'h01;

    // Wide enough for a dwell of up to four cycles per step.
    localparam int unsigned DWELL_W = 2;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle between requester, controller and datapath.
interface aes_round_ctrl_if;

    logic       start_valid;
    logic       start_ready;
    logic       abort;
    logic       load_en;
    logic       round_en;
    logic       mix_bypass;
    logic [3:0] round_idx;
    logic [7:0] rcon;
    logic       busy;
    logic       out_valid;
    logic       out_ready;

    // Requester / consumer / datapath side.
    modport master (
        output start_valid,
        output abort,
        output out_ready,
        input  start_ready,
        input  load_en,
        input  round_en,
        input  mix_bypass,
        input  round_idx,
        input  rcon,
        input  busy,
        input  out_valid
    );

    // Controller side.
    modport slave (
        input  start_valid,
        input  abort,
        input  out_ready,
        output start_ready,
        output load_en,
        output round_en,
        output mix_bypass,
        output round_idx,
        output rcon,
        output busy,
        output out_valid
    );

endinterface

// File: rtl/aes_rcon_gen.sv
// Registered AES key-schedule round constant: load seeds 0x01, advance applies xtime.
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] rcon
);

    logic [7:0] rcon_q;
    logic [7:0] rcon_d;

    // Next constant: clear wins over load, load wins over advance.
    always_comb begin
        rcon_d = rcon_q;
        if (clear) begin
            rcon_d = 8'h00;
        end else if (load) begin
            rcon_d = RCON_INIT;
        end else if (advance) begin
            rcon_d = xtime(rcon_q);
        end
    end

    // Constant register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcon_q <= 8'h00;
        end else begin
            rcon_q <= rcon_d;
        end
    end

    assign rcon = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: load step, nine full rounds, a final round without
// MixColumns, then holds the result until the consumer accepts it.
module aes_round_ctrl
    import aes_pkg::*;
#(
    // Cycles per step; legal range 1..4.
    parameter int unsigned ROUND_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    aes_round_ctrl_if.slave bus
);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(ROUND_CYCLES - 1);
    localparam logic [3:0]         LAST_FULL  = 4'(NUM_ROUNDS - 1);

    aes_state_e         state_q;
    aes_state_e         state_d;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_d;
    logic [3:0]         idx_q;
    logic [3:0]         idx_d;

    logic       in_step;
    logic       step_last;
    logic       rcon_clear;
    logic       rcon_load;
    logic       rcon_advance;
    logic [7:0] rcon_val;

    assign in_step   = (state_q == StLoad) || (state_q == StRound) || (state_q == StFinal);
    assign step_last = in_step && (dwell_q == DWELL_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; abort cancels any block in flight but is ignored while idle.
    always_comb begin
        state_d = state_q;
        if ((state_q != StIdle) && bus.abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (bus.start_valid)              state_d = StLoad;
                StLoad:  if (step_last)                    state_d = StRound;
                StRound: if (step_last && idx_q == LAST_FULL) state_d = StFinal;
                StFinal: if (step_last)                    state_d = StDone;
                StDone:  if (bus.out_ready)                state_d = StIdle;
                default:                                   state_d = StIdle;
            endcase
        end
    end

    // Outputs decoded from the current state and dwell position only.
    always_comb begin
        bus.start_ready = (state_q == StIdle);
        bus.busy        = (state_q != StIdle);
        bus.load_en     = (state_q == StLoad) && step_last;
        bus.round_en    = ((state_q == StRound) || (state_q == StFinal)) && step_last;
        bus.mix_bypass  = (state_q == StFinal) && step_last;
        bus.out_valid   = (state_q == StDone);
        bus.round_idx   = idx_q;
        bus.rcon        = rcon_val;
    end

    // Dwell counter restarts on every step boundary; round index advances after each commit.
    always_comb begin
        dwell_d = dwell_q + DWELL_W'(1);
        if (!in_step || step_last || (state_d == StIdle)) begin
            dwell_d = '0;
        end
        idx_d = idx_q;
        if (state_d == StIdle) begin
            idx_d = 4'd0;
        end else if (step_last && ((state_q == StLoad) || (state_q == StRound))) begin
            idx_d = idx_q + 4'd1;
        end
    end

    // Dwell and round-index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q <= '0;
            idx_q   <= 4'd0;
        end else begin
            dwell_q <= dwell_d;
            idx_q   <= idx_d;
        end
    end

    // The constant tracks round_idx: seeded entering round 1, stepped entering rounds 2..10.
    always_comb begin
        rcon_clear   = (state_d == StIdle);
        rcon_load    = (state_q == StLoad) && step_last;
        rcon_advance = (state_q == StRound) && step_last;
    end

    aes_rcon_gen u_rcon_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (rcon_clear),
        .load    (rcon_load),
        .advance (rcon_advance),
        .rcon    (rcon_val)
    );

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench: two controllers (ROUND_CYCLES 1 and 3) driven with randomized blocks,
// stalls, aborts and a mid-block reset; a monitor per lane checks every pulse and completion.
module tb_aes_round_ctrl;

    typedef struct {
        int t;
        int kind;  // 0 load, 1 round, 2 completion
        int idx;
        int rcon;
        int mix;
    } ev_t;

    localparam logic [17:0] RST_STATUS = {1'b1, 5'b00000, 4'd0, 8'h00};

    int rcon_tbl [11] = '{0, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    logic clk = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   lane_done [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input int ln, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL lane%0d %s: got %0d expected %0d (cycle %0d)", ln, name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int unsigned RC  = (g == 0) ? 1 : 3;
        localparam int          RCI = int'(RC);

        logic rst = 1'b1;
        logic [17:0] status;
        ev_t exp_q [$];
        logic ov_q = 1'b0;
        logic pbusy = 1'b0;
        logic ppulse = 1'b0;
        logic [3:0] pidx = 4'd0;

        aes_round_ctrl_if bus ();

        aes_round_ctrl #(.ROUND_CYCLES(RC)) dut (
            .clk   (clk),
            .rst_n (rst),
            .bus   (bus)
        );

        assign status = {bus.start_ready, bus.busy, bus.load_en, bus.round_en, bus.mix_bypass,
                         bus.out_valid, bus.round_idx, bus.rcon};

        // Monitor: every pulse or completion must match the head of the expected queue.
        always @(negedge clk) begin
            int kind;
            ev_t e;
            kind = bus.round_en ? 1 : (bus.load_en ? 0 : ((bus.out_valid && !ov_q) ? 2 : -1));
            if (kind >= 0) begin
                chk(exp_q.size() != 0, g, "unexpected_event", kind, -1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk(e.t == cyc, g, "event_time", cyc, e.t);
                    chk(e.kind == kind, g, "event_kind", kind, e.kind);
                    chk(e.idx == int'(bus.round_idx), g, "event_round_idx", int'(bus.round_idx), e.idx);
                    chk(e.rcon == int'(bus.rcon), g, "event_rcon", int'(bus.rcon), e.rcon);
                    chk(e.mix == int'(bus.mix_bypass), g, "event_mix", int'(bus.mix_bypass), e.mix);
                end
            end
            if (bus.mix_bypass) chk(bus.round_en, g, "mix_without_round", 0, 1);
            if (bus.out_valid) begin
                chk(bus.round_idx == 4'd10 && bus.rcon == 8'h36 && !bus.load_en && !bus.round_en,
                    g, "done_hold", int'(bus.round_idx), 10);
            end
            if (bus.busy && pbusy && !ppulse) begin
                chk(bus.round_idx == pidx, g, "idx_stable", int'(bus.round_idx), int'(pidx));
            end
            ov_q   <= bus.out_valid;
            pbusy  <= bus.busy;
            ppulse <= bus.load_en | bus.round_en;
            pidx   <= bus.round_idx;
        end

        // Driver and reference model.
        initial begin
            int n, t0, end_s, limit, ev_s, stall, ab_round, ab_off;
            bit noise, hold, do_ab, do_rst, ab_idle, ab_done, stop;
            bus.start_valid = 1'b0;
            bus.abort       = 1'b0;
            bus.out_ready   = 1'b0;
            #1 rst = 1'b0;
            repeat (2) @(negedge clk);
            chk(status == RST_STATUS, g, "reset_state", int'(status), int'(RST_STATUS));
            #2 rst = 1'b1;
            @(negedge clk);
            chk(status == RST_STATUS, g, "post_reset_idle", int'(status), int'(RST_STATUS));

            for (int sc = 0; sc < 12; sc++) begin
                stall = 0; noise = 0; hold = 0; do_ab = 0; do_rst = 0;
                ab_idle = 0; ab_done = 0; ab_round = 0; ab_off = 0;
                case (sc)
                    1: begin stall = 20; hold = 1; end
                    3: begin do_ab = 1; ab_round = 5; end
                    5: do_rst = 1;
                    6: ab_idle = 1;
                    7: begin ab_done = 1; stall = 2; end
                    8, 9, 10, 11: begin
                        stall    = int'($urandom_range(0, 5));
                        noise    = 1;
                        do_ab    = bit'($urandom_range(0, 1));
                        ab_round = int'($urandom_range(0, 10));
                        ab_off   = int'($urandom_range(0, RC - 1));
                    end
                    default: ;
                endcase

                n = 0;
                while (!bus.start_ready && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                chk(n < 100, g, "idle_wait", n, 0);
                if (sc == 2) chk(n == 0, g, "accept_after_pop", n, 0);

                // Expected events of this block, truncated at an abort or reset.
                t0    = cyc + 1;
                limit = 1 << 30;
                ev_s  = -1;
                if (do_ab) ev_s = t0 + RCI * ab_round + ab_off;
                if (do_rst) ev_s = t0 + RCI * 7;
                if (ev_s >= 0) limit = ev_s;
                if (t0 + RCI - 1 <= limit) exp_q.push_back('{t0 + RCI - 1, 0, 0, 0, 0});
                for (int r = 1; r <= 10; r++) begin
                    if (t0 + RCI * (r + 1) - 1 <= limit) begin
                        exp_q.push_back('{t0 + RCI * (r + 1) - 1, 1, r, rcon_tbl[r], (r == 10) ? 1 : 0});
                    end
                end
                end_s = t0 + 11 * RCI;
                if (end_s <= limit) exp_q.push_back('{end_s, 2, 10, rcon_tbl[10], 0});

                bus.start_valid = 1'b1;
                bus.abort       = ab_idle;
                bus.out_ready   = (stall == 0);
                @(negedge clk);
                bus.abort = 1'b0;

                stop = 0;
                while (!stop && cyc < end_s) begin
                    bus.start_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                    if (cyc == ev_s) begin
                        stop = 1;
                        bus.start_valid = 1'b0;
                        chk(int'(bus.round_idx) == (do_rst ? 7 : ab_round), g, "cancel_round_idx",
                            int'(bus.round_idx), do_rst ? 7 : ab_round);
                        if (do_ab) begin
                            bus.abort = 1'b1;
                            @(negedge clk);
                            bus.abort = 1'b0;
                            chk(!bus.busy && bus.start_ready && !bus.out_valid, g, "abort_to_idle",
                                int'(status), int'(RST_STATUS));
                        end else begin
                            #2 rst = 1'b0;
                            #1 chk(status == RST_STATUS, g, "async_reset", int'(status), int'(RST_STATUS));
                            repeat (2) @(negedge clk);
                            #2 rst = 1'b1;
                            @(negedge clk);
                            chk(status == RST_STATUS, g, "reset_release", int'(status), int'(RST_STATUS));
                        end
                    end else begin
                        @(negedge clk);
                    end
                end

                if (!stop) begin
                    bus.start_valid = hold;
                    repeat (stall) @(negedge clk);
                    bus.out_ready   = 1'b1;
                    bus.abort       = ab_done;
                    bus.start_valid = 1'b0;
                    @(negedge clk);
                    bus.out_ready = 1'b0;
                    bus.abort     = 1'b0;
                    chk(!bus.busy && bus.start_ready && !bus.out_valid, g, "pop_to_idle",
                        int'(status), int'(RST_STATUS));
                end
            end

            n = 0;
            while (exp_q.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk(exp_q.size() == 0, g, "drain", exp_q.size(), 0);
            lane_done[g] = 1'b1;
        end
    end

    initial begin
        int w;
        w = 0;
        while (!(lane_done[0] && lane_done[1]) && w < 20000) begin
            @(negedge clk);
            w++;
        end
        chk(w < 20000, -1, "lanes_finished", w, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
